// File: rtl/multicycle_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl_pkg
//
// Shared definitions for the multicycle control unit:
//   - RISC-V base opcodes recognised by the decoder
//   - the controller state encoding (visible on the 'state' output)
//   - ALU operation codes driven on 'aluop'
//   - an internal opcode classification and the Moore control bundle,
//     plus helpers that classify an opcode and decode per-state controls
//
// Optional feature macro used by the design: PERF_CNT_EN (performance counters)
// ----------------------------------------------------------------------------
package multicycle_ctrl_pkg;

    // Opcodes accepted by the decoder; anything else is flagged illegal
    localparam logic [6:0] OPC_R_TYPE = 7'b0110011;
    localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // ALU operation codes
    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    // Width of the performance counters
    localparam int CNT_W = 64;

    // Controller states; the numeric values are visible to software/debug
    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4,
        ST_HALT    = 3'd5
    } state_t;

    // Instruction class derived from the opcode and held for the rest of
    // the instruction once DECODE is done
    typedef enum logic [2:0] {
        CLS_R_TYPE  = 3'd0,
        CLS_I_ALU   = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_ILLEGAL = 3'd5
    } op_class_t;

    // Controls that depend only on state and instruction class
    typedef struct packed {
        logic       regwrite;
        logic       memtoreg;
        logic       alusrc;
        logic [1:0] aluop;
    } moore_ctrl_t;

    // Map a raw 7-bit opcode onto an instruction class
    function automatic op_class_t classify_opcode(input logic [6:0] opcode);
        op_class_t cls;
        case (opcode)
            OPC_R_TYPE: cls = CLS_R_TYPE;
            OPC_I_ALU:  cls = CLS_I_ALU;
            OPC_LOAD:   cls = CLS_LOAD;
            OPC_STORE:  cls = CLS_STORE;
            OPC_BRANCH: cls = CLS_BRANCH;
            default:    cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

    // Moore control decode for the state about to be entered.  ALU controls
    // are only meaningful once the instruction is past DECODE, so FETCH,
    // DECODE and HALT all leave them at zero.
    function automatic moore_ctrl_t decode_moore(input state_t st, input op_class_t cls);
        moore_ctrl_t m;
        logic        active;
        m      = '0;
        active = (st == ST_EXECUTE) || (st == ST_MEM) || (st == ST_WB);
        if (active) begin
            case (cls)
                CLS_LOAD, CLS_STORE: m.aluop = ALUOP_ADD;
                CLS_BRANCH:          m.aluop = ALUOP_BRANCH;
                default:             m.aluop = ALUOP_FUNCT;
            endcase
            m.alusrc = (cls == CLS_I_ALU) || (cls == CLS_LOAD) || (cls == CLS_STORE);
        end
        m.regwrite = (st == ST_WB);
        m.memtoreg = (st == ST_WB) && (cls == CLS_LOAD);
        return m;
    endfunction

endpackage

// File: rtl/mc_perf_counter.sv
// ----------------------------------------------------------------------------
// mc_perf_counter
//
// Performance counters for the multicycle controller.  Only compiled when
// PERF_CNT_EN is defined, so a default build carries no counter flops.
//
// Ports:
//   clk          - clock, counters update on the rising edge
//   reset        - asynchronous active-high reset, clears both counters
//   instr_done   - one-cycle pulse marking instruction retirement
//   cycle_count  - cycles since reset, saturating at all-ones
//   instret      - number of retired instructions
// ----------------------------------------------------------------------------
`ifdef PERF_CNT_EN
module mc_perf_counter
    import multicycle_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_done,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret
);

    // Cycle counter: sticks at all-ones rather than wrapping so a very long
    // run never reads back as a short one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count <= '0;
        end else if (cycle_count != '1) begin
            cycle_count <= cycle_count + 1'b1;
        end
    end

    // Retired-instruction counter, one step per instr_done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instret <= '0;
        end else if (instr_done) begin
            instret <= instret + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl
//
// Control unit for a multicycle RISC-V datapath.  Sequences each instruction
// through FETCH, DECODE, EXECUTE, MEM and WB, waits on instruction/data
// memory handshakes, flags illegal opcodes, and halts if a memory never
// answers.
//
// Parameters:
//   MAX_WAIT      - consecutive not-ready cycles in FETCH or MEM before HALT
//
// Ports:
//   clk, reset    - rising-edge clock, asynchronous active-high reset
//   instruction   - instruction-register contents, opcode in bits [6:0]
//   branch_finale - branch outcome (1 = taken)
//   imem_ready    - instruction fetch completes this cycle
//   dmem_ready    - data access completes this cycle
//   pc_write      - PC update strobe; pc_src picks branch target (1) or PC+4
//   ir_write      - instruction-register load strobe
//   memread, memwrite, memtoreg, alusrc, regwrite, aluop - datapath controls
//   state         - current controller state
//   instr_done    - pulse in the last cycle of every instruction
//   illegal_op    - sticky: an unknown opcode was decoded
//   timeout_err   - sticky: a memory wait exceeded MAX_WAIT
//   cycle_count, instret - performance counters (zero unless enabled)
//
// Configuration macro: PERF_CNT_EN enables the performance counters.
// ----------------------------------------------------------------------------
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 15
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        branch_finale,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        pc_src,
    output logic        memread,
    output logic        memwrite,
    output logic        memtoreg,
    output logic        alusrc,
    output logic        regwrite,
    output logic [1:0]  aluop,
    output logic [2:0]  state,
    output logic        instr_done,
    output logic        illegal_op,
    output logic        timeout_err,
    output logic [63:0] cycle_count,
    output logic [63:0] instret
);

    localparam int                WAIT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    state_t            cur_state;
    state_t            nxt_state;
    op_class_t         op_class;
    op_class_t         nxt_class;
    op_class_t         dec_class;
    logic [WAIT_W-1:0] wait_cnt;
    logic              stall;
    moore_ctrl_t       moore_q;
    logic              unused_instr_bits;

    // Only the opcode field matters to the controller
    assign dec_class         = classify_opcode(instruction[6:0]);
    assign unused_instr_bits = ^instruction[31:7];

    // Next-state logic.  Ready inputs are looked at only in the two waiting
    // states; a wait that reaches its limit diverts to HALT instead of
    // spinning forever.  The instruction class is captured on the way out
    // of DECODE so later states don't depend on the IR staying stable.
    always_comb begin
        nxt_state = cur_state;
        nxt_class = op_class;
        stall     = 1'b0;
        case (cur_state)
            ST_FETCH: begin
                if (imem_ready) begin
                    nxt_state = ST_DECODE;
                end else begin
                    stall = 1'b1;
                    if (wait_cnt == WAIT_LAST) begin
                        nxt_state = ST_HALT;
                    end
                end
            end
            ST_DECODE: begin
                nxt_class = dec_class;
                nxt_state = (dec_class == CLS_ILLEGAL) ? ST_FETCH : ST_EXECUTE;
            end
            ST_EXECUTE: begin
                case (op_class)
                    CLS_LOAD, CLS_STORE: nxt_state = ST_MEM;
                    CLS_BRANCH:          nxt_state = ST_FETCH;
                    default:             nxt_state = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (dmem_ready) begin
                    nxt_state = (op_class == CLS_STORE) ? ST_FETCH : ST_WB;
                end else begin
                    stall = 1'b1;
                    if (wait_cnt == WAIT_LAST) begin
                        nxt_state = ST_HALT;
                    end
                end
            end
            ST_WB:   nxt_state = ST_FETCH;
            ST_HALT: nxt_state = ST_HALT;
            default: nxt_state = ST_FETCH;
        endcase
    end

    // State register plus the registered Moore controls and sticky error
    // flags.  The wait counter only keeps counting while we stay in the same
    // waiting state, so it starts from zero on every FETCH/MEM entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state   <= ST_FETCH;
            op_class    <= CLS_R_TYPE;
            wait_cnt    <= '0;
            moore_q     <= '0;
            illegal_op  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            op_class  <= nxt_class;
            moore_q   <= decode_moore(nxt_state, nxt_class);
            if (stall && (nxt_state == cur_state)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if ((cur_state == ST_DECODE) && (dec_class == CLS_ILLEGAL)) begin
                illegal_op <= 1'b1;
            end
            if (nxt_state == ST_HALT) begin
                timeout_err <= 1'b1;
            end
        end
    end

    // Handshake-dependent strobes.  These must react to the ready inputs in
    // the same cycle (IR load, store completion), so they are decoded from
    // the current state rather than registered.  Gating with reset makes the
    // memory strobes drop the moment reset rises, even between clock edges.
    always_comb begin
        memread    = 1'b0;
        memwrite   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        instr_done = 1'b0;
        if (!reset) begin
            case (cur_state)
                ST_FETCH: begin
                    memread  = 1'b1;
                    ir_write = imem_ready;
                end
                ST_DECODE: begin
                    if (dec_class == CLS_ILLEGAL) begin
                        pc_write   = 1'b1;
                        instr_done = 1'b1;
                    end
                end
                ST_EXECUTE: begin
                    if (op_class == CLS_BRANCH) begin
                        pc_write   = 1'b1;
                        pc_src     = branch_finale;
                        instr_done = 1'b1;
                    end
                end
                ST_MEM: begin
                    if (op_class == CLS_STORE) begin
                        memwrite   = 1'b1;
                        pc_write   = dmem_ready;
                        instr_done = dmem_ready;
                    end else begin
                        memread = 1'b1;
                    end
                end
                ST_WB: begin
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign regwrite = moore_q.regwrite;
    assign memtoreg = moore_q.memtoreg;
    assign alusrc   = moore_q.alusrc;
    assign aluop    = moore_q.aluop;
    assign state    = cur_state;

`ifdef PERF_CNT_EN
    mc_perf_counter u_perf_counter (
        .clk         (clk),
        .reset       (reset),
        .instr_done  (instr_done),
        .cycle_count (cycle_count),
        .instret     (instret)
    );
`else
    assign cycle_count = '0;
    assign instret     = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Self-checking bench for multicycle_ctrl.  Each instruction is expanded by a
// reference model into its expected cycle-by-cycle timeline (states, strobes,
// ready handshakes) built straight from the instruction-level rules; the
// bench then drives that timeline into the DUT with random noise on any
// input the controller must ignore, and compares every cycle.
// ----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instruction = '0;
    logic        branch_finale = 1'b0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        pc_write, ir_write, pc_src, memread, memwrite;
    logic        memtoreg, alusrc, regwrite, instr_done;
    logic        illegal_op, timeout_err;
    logic [1:0]  aluop;
    logic [2:0]  state;
    logic [63:0] cycle_count, instret;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl #(.MAX_WAIT(15)) dut (
        .clk           (clk),
        .reset         (reset),
        .instruction   (instruction),
        .branch_finale (branch_finale),
        .imem_ready    (imem_ready),
        .dmem_ready    (dmem_ready),
        .pc_write      (pc_write),
        .ir_write      (ir_write),
        .pc_src        (pc_src),
        .memread       (memread),
        .memwrite      (memwrite),
        .memtoreg      (memtoreg),
        .alusrc        (alusrc),
        .regwrite      (regwrite),
        .aluop         (aluop),
        .state         (state),
        .instr_done    (instr_done),
        .illegal_op    (illegal_op),
        .timeout_err   (timeout_err),
        .cycle_count   (cycle_count),
        .instret       (instret)
    );

    always #5 clk = ~clk;

    // Instruction kinds used by the model
    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_ILL = 5;

    // One expected cycle: the state, the ready value the controller samples,
    // and every expected output
    typedef struct {
        logic [2:0]  st;
        logic [31:0] instr;
        logic        imr, dmr, bf, use_bf;
        logic        mr, mw, irw, pcw, pcs, done, rw, mtr, asrc, ill;
        logic [1:0]  aop;
    } cyc_t;

    cyc_t        plan[$];
    logic        exp_illegal = 1'b0;
    logic        exp_timeout = 1'b0;
    logic [63:0] exp_cycles = '0;
    logic [63:0] exp_instret = '0;
    bit          tie_ready = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic cyc_t blank_cycle(input logic [2:0] st, input logic [31:0] instr);
        cyc_t c;
        c = '{st: st, instr: instr, imr: 1'b0, dmr: 1'b0, bf: 1'b0, use_bf: 1'b0,
              mr: 1'b0, mw: 1'b0, irw: 1'b0, pcw: 1'b0, pcs: 1'b0, done: 1'b0,
              rw: 1'b0, mtr: 1'b0, asrc: 1'b0, ill: 1'b0, aop: 2'b00};
        return c;
    endfunction

    function automatic logic is_legal(input logic [6:0] op);
        return (op == 7'b0110011) || (op == 7'b0010011) || (op == 7'b0000011) ||
               (op == 7'b0100011) || (op == 7'b1100011);
    endfunction

    function automatic logic [31:0] make_word(input int kind);
        logic [6:0] op;
        case (kind)
            K_R:     op = 7'b0110011;
            K_I:     op = 7'b0010011;
            K_LD:    op = 7'b0000011;
            K_ST:    op = 7'b0100011;
            K_BR:    op = 7'b1100011;
            default: begin
                do op = 7'($urandom); while (is_legal(op));
            end
        endcase
        return {25'($urandom), op};
    endfunction

    // Reference model: expand one instruction into its expected timeline.
    // fw/dw are the number of not-ready cycles before the fetch/data access
    // completes.
    task automatic plan_instr(input int kind, input int fw, input int dw,
                              input logic bf, input logic [31:0] word);
        cyc_t       c;
        logic       asrc;
        logic [1:0] aop;
        asrc = (kind == K_I) || (kind == K_LD) || (kind == K_ST);
        aop  = (kind == K_BR) ? 2'b01 : ((kind == K_LD) || (kind == K_ST)) ? 2'b00 : 2'b10;
        for (int i = 0; i < fw; i++) begin
            c = blank_cycle(3'd0, word);
            c.mr = 1'b1;
            plan.push_back(c);
        end
        c = blank_cycle(3'd0, word);
        c.mr = 1'b1; c.imr = 1'b1; c.irw = 1'b1;
        plan.push_back(c);
        c = blank_cycle(3'd1, word);
        if (kind == K_ILL) begin
            c.pcw = 1'b1; c.done = 1'b1; c.ill = 1'b1;
            plan.push_back(c);
            return;
        end
        plan.push_back(c);
        // after DECODE the IR contents are irrelevant, so scramble them
        c = blank_cycle(3'd2, $urandom);
        c.asrc = asrc; c.aop = aop;
        if (kind == K_BR) begin
            c.use_bf = 1'b1; c.bf = bf; c.pcw = 1'b1; c.pcs = bf; c.done = 1'b1;
            plan.push_back(c);
            return;
        end
        plan.push_back(c);
        if ((kind == K_LD) || (kind == K_ST)) begin
            for (int i = 0; i <= dw; i++) begin
                c = blank_cycle(3'd3, $urandom);
                c.asrc = asrc; c.aop = aop;
                c.dmr = (i == dw);
                if (kind == K_ST) begin
                    c.mw = 1'b1; c.pcw = c.dmr; c.done = c.dmr;
                end else begin
                    c.mr = 1'b1;
                end
                plan.push_back(c);
            end
            if (kind == K_ST) return;
        end
        c = blank_cycle(3'd4, $urandom);
        c.asrc = asrc; c.aop = aop;
        c.rw = 1'b1; c.pcw = 1'b1; c.done = 1'b1; c.mtr = (kind == K_LD);
        plan.push_back(c);
    endtask

    // Drive one cycle: sampled ready lines follow the plan, others are noise
    task automatic applyStimulus(input cyc_t c);
        instruction   = c.instr;
        imem_ready    = (c.st == 3'd0) ? c.imr : (tie_ready ? 1'b1 : 1'($urandom));
        dmem_ready    = (c.st == 3'd3) ? c.dmr : (tie_ready ? 1'b1 : 1'($urandom));
        branch_finale = c.use_bf ? c.bf : 1'($urandom);
        #1;
    endtask

    task automatic checkOutput(input cyc_t c, input string name, input int idx);
        string p;
        p = $sformatf("%s[%0d]", name, idx);
        if (c.st == 3'd5) exp_timeout = 1'b1;
        check_val({p, " state"},       64'(state),       64'(c.st));
        check_val({p, " memread"},     64'(memread),     64'(c.mr));
        check_val({p, " memwrite"},    64'(memwrite),    64'(c.mw));
        check_val({p, " ir_write"},    64'(ir_write),    64'(c.irw));
        check_val({p, " pc_write"},    64'(pc_write),    64'(c.pcw));
        check_val({p, " pc_src"},      64'(pc_src),      64'(c.pcs));
        check_val({p, " instr_done"},  64'(instr_done),  64'(c.done));
        check_val({p, " regwrite"},    64'(regwrite),    64'(c.rw));
        check_val({p, " memtoreg"},    64'(memtoreg),    64'(c.mtr));
        check_val({p, " alusrc"},      64'(alusrc),      64'(c.asrc));
        check_val({p, " aluop"},       64'(aluop),       64'(c.aop));
        check_val({p, " illegal_op"},  64'(illegal_op),  64'(exp_illegal));
        check_val({p, " timeout_err"}, 64'(timeout_err), 64'(exp_timeout));
`ifdef PERF_CNT_EN
        check_val({p, " cycle_count"}, cycle_count, exp_cycles);
        check_val({p, " instret"},     instret,     exp_instret);
`else
        check_val({p, " cycle_count"}, cycle_count, 64'd0);
        check_val({p, " instret"},     instret,     64'd0);
`endif
        if (c.ill) exp_illegal = 1'b1;
        if (c.done) exp_instret = exp_instret + 64'd1;
        exp_cycles = exp_cycles + 64'd1;
    endtask

    // Run up to max_cycles planned cycles; done_at reports the first cycle
    // (1-based) in which the DUT raised instr_done, 0 if it never did
    task automatic run_plan(input string name, input int max_cycles, output int done_at);
        cyc_t c;
        int   idx;
        idx     = 0;
        done_at = 0;
        while ((plan.size() > 0) && (idx < max_cycles)) begin
            c = plan.pop_front();
            idx++;
            applyStimulus(c);
            if ((done_at == 0) && (instr_done === 1'b1)) done_at = idx;
            checkOutput(c, name, idx);
            @(negedge clk);
        end
    endtask

    // Raise reset (possibly mid-cycle), confirm the reset state while the
    // inputs try hard to provoke strobes, then release on a falling edge
    task automatic do_reset(input string name);
        reset         = 1'b1;
        imem_ready    = 1'b1;
        dmem_ready    = 1'b1;
        branch_finale = 1'b1;
        instruction   = 32'h0020_A023;
        #1;
        check_val({name, " state"},       64'(state),       64'd0);
        check_val({name, " memread"},     64'(memread),     64'd0);
        check_val({name, " memwrite"},    64'(memwrite),    64'd0);
        check_val({name, " ir_write"},    64'(ir_write),    64'd0);
        check_val({name, " pc_write"},    64'(pc_write),    64'd0);
        check_val({name, " instr_done"},  64'(instr_done),  64'd0);
        check_val({name, " regwrite"},    64'(regwrite),    64'd0);
        check_val({name, " aluop"},       64'(aluop),       64'd0);
        check_val({name, " alusrc"},      64'(alusrc),      64'd0);
        check_val({name, " illegal_op"},  64'(illegal_op),  64'd0);
        check_val({name, " timeout_err"}, 64'(timeout_err), 64'd0);
        check_val({name, " cycle_count"}, cycle_count,      64'd0);
        check_val({name, " instret"},     instret,          64'd0);
        @(negedge clk);
        @(negedge clk);
        reset       = 1'b0;
        exp_illegal = 1'b0;
        exp_timeout = 1'b0;
        exp_cycles  = '0;
        exp_instret = '0;
    endtask

    initial begin
        int   done_at;
        int   kind;
        cyc_t c;

        do_reset("por");

        // add x3,x1,x2 with both ready lines held high
        tie_ready = 1'b1;
        plan_instr(K_R, 0, 0, 1'b0, 32'h0020_81B3);
        run_plan("add", 100, done_at);
        check_val("add latency", 64'(done_at), 64'd4);
        tie_ready = 1'b0;

        // lw x5,0(x1) with three data wait cycles
        plan_instr(K_LD, 0, 3, 1'b0, 32'h0000_A283);
        run_plan("lw", 100, done_at);
        check_val("lw latency", 64'(done_at), 64'd8);

        // beq taken
        plan_instr(K_BR, 0, 0, 1'b1, 32'h0020_8463);
        run_plan("beq", 100, done_at);
        check_val("beq latency", 64'(done_at), 64'd3);

        // illegal opcode, then a normal instruction to show fetch resumes
        plan_instr(K_ILL, 0, 0, 1'b0, 32'h0000_007F);
        run_plan("illegal", 100, done_at);
        check_val("illegal latency", 64'(done_at), 64'd2);
        plan_instr(K_I, 1, 0, 1'b0, 32'h0050_8093);
        run_plan("addi", 100, done_at);
        check_val("addi latency", 64'(done_at), 64'd5);

        // longest legal waits (one short of the limit) on both memories
        plan_instr(K_ST, 14, 14, 1'b0, 32'h0020_A023);
        run_plan("sw_maxwait", 100, done_at);
        check_val("sw_maxwait latency", 64'(done_at), 64'd32);

        // random instruction stream
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 5);
            plan_instr(kind, $urandom_range(0, 3), $urandom_range(0, 3),
                       1'($urandom), make_word(kind));
        end
        run_plan("rand", 2000, done_at);

        // instruction memory never answers: halt after the wait limit
        for (int i = 0; i < 15; i++) begin
            c = blank_cycle(3'd0, $urandom);
            c.mr = 1'b1;
            plan.push_back(c);
        end
        for (int i = 0; i < 6; i++) begin
            plan.push_back(blank_cycle(3'd5, $urandom));
        end
        run_plan("timeout", 100, done_at);
        check_val("timeout no done", 64'(done_at), 64'd0);
        do_reset("post_halt");

        // reset in the middle of a store's data wait
        plan_instr(K_ST, 1, 6, 1'b0, 32'h0020_A023);
        run_plan("sw_pre", 5, done_at);
        c = plan.pop_front();
        applyStimulus(c);
        checkOutput(c, "sw_pre", 6);
        do_reset("sw_reset");
        plan.delete();

        // recovery after reset
        plan_instr(K_R, 0, 0, 1'b0, 32'h0020_81B3);
        run_plan("add_after", 100, done_at);
        check_val("add_after latency", 64'(done_at), 64'd4);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
